// File: rtl/masked_sequence_detector.sv
// masked_sequence_detector: slides a masked pattern over a word stream and reports per-offset matches.
module masked_sequence_detector #(
   parameter  int WID_Bitstream = 8,
   parameter  int WID_Compair   = 16,
   parameter  int WID_Count     = 16,
   localparam int NUM_Buffer    = (WID_Compair + 2 * WID_Bitstream - 2) / WID_Bitstream,
   localparam int WID_Buffer    = NUM_Buffer * WID_Bitstream,
   localparam int WID_Index     = (WID_Bitstream > 1) ? $clog2(WID_Bitstream) : 1,
   localparam int WID_Fill      = $clog2(NUM_Buffer + 1)
) (
   input  logic                     local_MSD_clk,
   input  logic                     local_MSD_reset,
   input  logic                     local_MSD_newstream,
   input  logic                     local_MSD_stop,
   input  logic [WID_Compair-1:0]   local_MSD_compair,
   input  logic [WID_Compair-1:0]   local_MSD_mask,
   input  logic                     local_MSD_valid,
   input  logic [WID_Bitstream-1:0] local_MSD_bitstream,
   output logic                     MSD_local_busy,
   output logic [WID_Bitstream-1:0] MSD_local_position,
   output logic                     MSD_local_hit,
   output logic [WID_Index-1:0]     MSD_local_first,
   output logic [WID_Count-1:0]     MSD_local_hitcount
);
   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, MATCH = 2'd2} state_t;
   state_t                          state;
   logic [WID_Buffer-1:0]           buffer, next_buffer;
   logic [WID_Buffer+WID_Bitstream-1:0] shifted;
   logic [WID_Compair-1:0]          pattern, mask;
   logic [WID_Fill-1:0]             fill_count;
   logic [WID_Bitstream-1:0]        next_position;
   logic [WID_Index-1:0]            next_first;
   logic                            accept, evaluate;

   assign MSD_local_busy = state != IDLE;

   always_comb begin
      shifted       = {local_MSD_bitstream, buffer} >> WID_Bitstream;
      next_buffer   = shifted[WID_Buffer-1:0];
      accept        = local_MSD_valid && !local_MSD_newstream && !local_MSD_stop && (state == FILL || state == MATCH);
      evaluate      = accept && (state == MATCH || fill_count == WID_Fill'(1));
      next_position = '0;
      next_first    = '0;
      // descending scan so the lowest matching offset is the one left in next_first
      for (int i = WID_Bitstream - 1; i >= 0; i--) begin
         next_position[i] = ~|((next_buffer[i +: WID_Compair] ^ pattern) & mask);
         if (next_position[i]) next_first = WID_Index'(i);
      end
   end

   always_ff @(posedge local_MSD_clk) begin
      if (local_MSD_reset) begin
         state              <= IDLE;
         buffer             <= '0;
         pattern            <= '0;
         mask               <= '0;
         fill_count         <= '0;
         MSD_local_position <= '0;
         MSD_local_hit      <= 1'b0;
         MSD_local_first    <= '0;
         MSD_local_hitcount <= '0;
      end else if (local_MSD_newstream) begin
         state              <= FILL;
         buffer             <= '0;
         pattern            <= local_MSD_compair;
         mask               <= local_MSD_mask;
         fill_count         <= WID_Fill'(NUM_Buffer);
         MSD_local_position <= '0;
         MSD_local_hit      <= 1'b0;
         MSD_local_first    <= '0;
         MSD_local_hitcount <= '0;
      end else if (local_MSD_stop) begin
         state         <= IDLE;
         MSD_local_hit <= 1'b0;
      end else begin
         MSD_local_hit <= 1'b0;
         case (state)
            IDLE: state <= IDLE;
            FILL, MATCH: begin
               if (accept) buffer <= next_buffer;
               if (accept && state == FILL) begin
                  fill_count <= fill_count - WID_Fill'(1);
                  if (fill_count == WID_Fill'(1)) state <= MATCH;
               end
               if (evaluate) begin
                  MSD_local_position <= next_position;
                  MSD_local_first    <= next_first;
                  MSD_local_hit      <= |next_position;
                  if (|next_position && ~&MSD_local_hitcount) MSD_local_hitcount <= MSD_local_hitcount + WID_Count'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_masked_sequence_detector.sv
// tb_masked_sequence_detector: directed vectors with hand-computed expectations.
module tb_masked_sequence_detector;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        newstream = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] compair = '0;
   logic [15:0] mask = '0;
   logic        valid = 1'b0;
   logic [7:0]  bitstream = '0;
   logic        busy, hit, busy2, hit2;
   logic [7:0]  position, position2;
   logic [2:0]  first, first2;
   logic [15:0] hitcount;
   logic [1:0]  hitcount2;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   masked_sequence_detector dut (
      .local_MSD_clk(clk), .local_MSD_reset(rst), .local_MSD_newstream(newstream), .local_MSD_stop(stop),
      .local_MSD_compair(compair), .local_MSD_mask(mask), .local_MSD_valid(valid), .local_MSD_bitstream(bitstream),
      .MSD_local_busy(busy), .MSD_local_position(position), .MSD_local_hit(hit),
      .MSD_local_first(first), .MSD_local_hitcount(hitcount)
   );

   masked_sequence_detector #(.WID_Count(2)) dut2 (
      .local_MSD_clk(clk), .local_MSD_reset(rst), .local_MSD_newstream(newstream), .local_MSD_stop(stop),
      .local_MSD_compair(compair), .local_MSD_mask(mask), .local_MSD_valid(valid), .local_MSD_bitstream(bitstream),
      .MSD_local_busy(busy2), .MSD_local_position(position2), .MSD_local_hit(hit2),
      .MSD_local_first(first2), .MSD_local_hitcount(hitcount2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [15:0] p, input logic [15:0] m);
      compair = p; mask = m; newstream = 1'b1;
      tick();
      newstream = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      valid = 1'b1; bitstream = d;
      tick();
      valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic b, input logic [7:0] p, input logic h,
                             input logic [2:0] f, input logic [15:0] c);
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".pos"}, 32'(position), 32'(p));
      check({tag, ".hit"}, 32'(hit), 32'(h));
      check({tag, ".first"}, 32'(first), 32'(f));
      check({tag, ".cnt"}, 32'(hitcount), 32'(c));
   endtask

   initial begin
      tick(); tick();
      expect_out("reset", 0, 8'h00, 0, 0, 0);
      rst = 1'b0;

      // exact pattern, back-to-back words
      start(16'hA5C3, 16'hFFFF);
      expect_out("t1.ns", 1, 8'h00, 0, 0, 0);
      send(8'hC3); expect_out("t1.w1", 1, 8'h00, 0, 0, 0);
      send(8'hA5); expect_out("t1.w2", 1, 8'h00, 0, 0, 0);
      send(8'h00); expect_out("t1.w3", 1, 8'h01, 1, 0, 1);
      tick();      expect_out("t1.gap", 1, 8'h01, 0, 0, 1);
      send(8'h12); expect_out("t1.w4", 1, 8'h00, 0, 0, 1);

      // same stream with 3-cycle gaps
      start(16'hA5C3, 16'hFFFF);
      expect_out("t2.ns", 1, 8'h00, 0, 0, 0);
      send(8'hC3);
      for (int i = 0; i < 3; i++) begin tick(); expect_out("t2.g1", 1, 8'h00, 0, 0, 0); end
      send(8'hA5);
      for (int i = 0; i < 3; i++) begin tick(); expect_out("t2.g2", 1, 8'h00, 0, 0, 0); end
      send(8'h00); expect_out("t2.w3", 1, 8'h01, 1, 0, 1);
      for (int i = 0; i < 3; i++) begin tick(); expect_out("t2.g3", 1, 8'h01, 0, 0, 1); end

      // all-zero mask
      start(16'h1234, 16'h0000);
      send(8'h5A); expect_out("t3.w1", 1, 8'h00, 0, 0, 0);
      send(8'h3C); expect_out("t3.w2", 1, 8'h00, 0, 0, 0);
      send(8'h99); expect_out("t3.w3", 1, 8'hFF, 1, 0, 1);
      send(8'h01); expect_out("t3.w4", 1, 8'hFF, 1, 0, 2);
      tick();      expect_out("t3.gap", 1, 8'hFF, 0, 0, 2);

      // newstream mid-MATCH; concurrent valid word must be dropped
      compair = 16'hA5C3; mask = 16'hFFFF; newstream = 1'b1; valid = 1'b1; bitstream = 8'h77;
      tick();
      newstream = 1'b0; valid = 1'b0;
      expect_out("t4.ns", 1, 8'h00, 0, 0, 0);
      send(8'hC3); expect_out("t4.w1", 1, 8'h00, 0, 0, 0);
      send(8'hA5); expect_out("t4.w2", 1, 8'h00, 0, 0, 0);
      send(8'h00); expect_out("t4.w3", 1, 8'h01, 1, 0, 1);

      // match at offset 3 only: buffer 0x0091A0 holds 0x1234 at bit 3
      start(16'h1234, 16'hFFFF);
      send(8'hA0); send(8'h91);
      send(8'h00); expect_out("t5.off3", 1, 8'h08, 1, 3, 1);

      // reset mid-MATCH with a word present
      valid = 1'b1; bitstream = 8'h00; rst = 1'b1;
      tick();
      valid = 1'b0; rst = 1'b0;
      expect_out("t6.rst", 0, 8'h00, 0, 0, 0);
      rst = 1'b1; newstream = 1'b1; stop = 1'b1;
      tick();
      rst = 1'b0; newstream = 1'b0; stop = 1'b0;
      expect_out("t6.rstwin", 0, 8'h00, 0, 0, 0);

      // stop mid-FILL, then later words ignored
      start(16'h0000, 16'h0000);
      send(8'h11);
      valid = 1'b1; bitstream = 8'h22; stop = 1'b1;
      tick();
      valid = 1'b0; stop = 1'b0;
      expect_out("t7.stop", 0, 8'h00, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin send(8'h33); expect_out("t7.ign", 0, 8'h00, 0, 0, 0); end

      // stop mid-MATCH keeps position/count
      start(16'h0000, 16'h0000);
      send(8'h01); send(8'h02); send(8'h03);
      expect_out("t8.hit", 1, 8'hFF, 1, 0, 1);
      stop = 1'b1; tick(); stop = 1'b0;
      expect_out("t8.stop", 0, 8'hFF, 0, 0, 1);
      send(8'h04); expect_out("t8.ign", 0, 8'hFF, 0, 0, 1);

      // 2-bit counter saturation on dut2
      start(16'hBEEF, 16'h0000);
      send(8'h01); send(8'h02);
      check("t9.pre", 32'(hitcount2), 32'd0);
      send(8'h03); check("t9.c1", 32'(hitcount2), 32'd1);
      send(8'h04); check("t9.c2", 32'(hitcount2), 32'd2);
      send(8'h05); check("t9.c3", 32'(hitcount2), 32'd3);
      send(8'h06); check("t9.c4", 32'(hitcount2), 32'd3);
      check("t9.hit2", 32'(hit2), 32'd1);
      check("t9.wide", 32'(hitcount), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/masked_sequence_detector.md
MASKED_SEQUENCE_DETECTOR -- requirements
Module: masked_sequence_detector

Interface
REQ-001 Parameter WID_Bitstream, default 8: width of one stream word and of the position vector; SHALL be >= 1.
REQ-002 Parameter WID_Compair, default 16: pattern and mask width; SHALL be >= 1.
REQ-003 Parameter WID_Count, default 16: hit-counter width; SHALL be >= 1.
REQ-004 Derived: NUM_Buffer = ceil((WID_Compair + WID_Bitstream - 1) / WID_Bitstream); WID_Buffer = NUM_Buffer * WID_Bitstream; WID_Index = max(1, clog2(WID_Bitstream)).
REQ-005 local_MSD_clk  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-006 local_MSD_reset  in  1  synchronous, active-high reset.
REQ-007 local_MSD_newstream  in  1  load pattern and mask; start a new search.
REQ-008 local_MSD_stop  in  1  abort the search; return to idle.
REQ-009 local_MSD_compair  in  WID_Compair  pattern, sampled only with newstream.
REQ-010 local_MSD_mask  in  WID_Compair  care mask (1 = compare bit), sampled only with newstream.
REQ-011 local_MSD_valid  in  1  bitstream word qualifier.
REQ-012 local_MSD_bitstream  in  WID_Bitstream  stream word.
REQ-013 MSD_local_busy  out  1  high when not IDLE.
REQ-014 MSD_local_position  out  WID_Bitstream  per-offset match vector of the last evaluation.
REQ-015 MSD_local_hit  out  1  one-cycle pulse: last evaluation had a nonzero position.
REQ-016 MSD_local_first  out  WID_Index  lowest set index of the position from that evaluation; 0 if none.
REQ-017 MSD_local_hitcount  out  WID_Count  saturating count of hit evaluations since newstream.

Function
REQ-018 States SHALL be IDLE, FILL, MATCH; any other encoding SHALL go to IDLE on the next edge.
REQ-019 A word is accepted when valid=1 and state is FILL or MATCH; on acceptance the buffer SHALL become {bitstream, buffer[WID_Buffer-1:WID_Bitstream]}. The buffer SHALL hold when no word is accepted.
REQ-020 Window i (0 <= i < WID_Bitstream) = nextbuffer[i+WID_Compair-1:i]. Offset i SHALL match iff ((window XOR pattern) AND mask) == 0.
REQ-021 newstream SHALL win in any state: latch compair/mask, clear buffer, position, first and hitcount, load fill count NUM_Buffer, enter FILL. The word on that cycle SHALL NOT be accepted.
REQ-022 FILL: each accepted word decrements the fill count. The NUM_Buffer-th accepted word SHALL move to MATCH and SHALL itself be evaluated.
REQ-023 MATCH: every accepted word SHALL be evaluated. Position, first and hit SHALL register on the accepting edge, giving a latency of 1 cycle from word to output.
REQ-024 hit SHALL be 0 on every cycle that does not follow a hit evaluation. Position and first SHALL hold between evaluations.
REQ-025 hitcount SHALL increment by 1 per hit evaluation and saturate at 2^WID_Count-1 without wrapping.
REQ-026 stop without newstream SHALL enter IDLE next edge, and no word is accepted on that cycle. Position, first and hitcount SHALL hold; hit SHALL go to 0.
REQ-027 An all-zero mask SHALL match every offset, giving an all-ones position.
REQ-028 IDLE SHALL ignore valid and bitstream.

Reset
REQ-029 While reset is high at an edge, the block SHALL enter IDLE and clear buffer, pattern, mask and fill count. All outputs SHALL be 0, busy included. Reset SHALL override newstream and stop.
REQ-030 Reset asserted in FILL or MATCH SHALL abort the search with no further hit.

Verification (WID_Bitstream=8, WID_Compair=16, so NUM_Buffer=3)
REQ-031 newstream with pattern 0xA5C3 and mask 0xFFFF, then valid words 0xC3, 0xA5, 0x00 -> after the third word: position 0x01, hit pulses for 1 cycle, first 0, hitcount 1, busy 1. No hit after the first two words.
REQ-032 Same stream with valid low for 3 cycles between each word -> identical result, delayed only. Outputs hold during the gaps.
REQ-033 mask 0x0000, any 3 words -> position 0xFF, first 0, hit on the 3rd word only. Each later word -> hitcount +1.
REQ-034 newstream mid-MATCH -> position, first and hitcount go to 0. The next 2 words give no hit, and the 3rd word is evaluated.
REQ-035 Reset mid-MATCH, then stop mid-FILL in a separate run -> reset: all outputs 0 and busy 0 next cycle. Stop: busy 0, hitcount held, later words ignored.
REQ-036 WID_Count=2, mask 0x0000, 6 matching words -> hitcount sequence 1, 2, 3, 3; no wrap.
